// File: rtl/ram_cache_pkg.sv
// ram_cache_pkg: shared state encoding and default sizing
// for the USB3-to-RAM burst cache.
package ram_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_BURST,
    ST_CLOSE
  } state_e;

  localparam int         DEF_DATA_W    = 32;
  localparam int         DEF_NUM_RAM   = 16;
  localparam int         DEF_BURST_LEN = 256;
  localparam logic [3:0] DEF_RD_CODE   = 4'd6;

endpackage

// File: rtl/ram_bank_dec.sv
// ram_bank_dec: bank index to one-hot write enable,
// all-zero when en_i is low.
module ram_bank_dec #(
  parameter  int NUM_RAM = 16,
  localparam int SEL_W   = $clog2(NUM_RAM)
) (
  input  logic [SEL_W-1:0]   bank_sel_i,
  input  logic               en_i,
  output logic [NUM_RAM-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_RAM; i++) begin
      if (en_i && bank_sel_i == SEL_W'(i)) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_cache_mc.sv
// ram_cache_mc: streams USB3 FIFO words into rotating RAM banks.
// Define RAM_CACHE_MC_STATS_EN for burst_cnt/short_cnt outputs.
module ram_cache_mc
  import ram_cache_pkg::*;
#(
  parameter  int         DATA_W    = DEF_DATA_W,
  parameter  int         NUM_RAM   = DEF_NUM_RAM,
  parameter  int         BURST_LEN = DEF_BURST_LEN,
  parameter  logic [3:0] RD_CODE   = DEF_RD_CODE,
  parameter  int         ADDR_W    = $clog2(BURST_LEN),
  localparam int         SEL_W     = $clog2(NUM_RAM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  data,
  input  logic [3:0]         usb_rd_state,
  input  logic               USB3_FLAGA,
  output logic [DATA_W-1:0]  q,
  output logic [ADDR_W-1:0]  wraddr,
  output logic [NUM_RAM-1:0] wren_for_ram,
  output logic [SEL_W-1:0]   bank_sel,
`ifdef RAM_CACHE_MC_STATS_EN
  output logic [15:0]        burst_cnt,
  output logic [15:0]        short_cnt,
`endif
  output logic               burst_done,
  output logic               short_burst,
  output logic               busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(BURST_LEN - 1);
  localparam logic [SEL_W-1:0]  LAST_BANK = SEL_W'(NUM_RAM - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   q_q;
  logic [ADDR_W-1:0]   wraddr_q;
  logic [NUM_RAM-1:0]  wren_q;
  logic [SEL_W-1:0]    bank_q;
  logic                done_q;
  logic                short_q;
  logic                busy_q;

  logic                rd_hit;
  logic                accept;
  logic                last;
  logic [ADDR_W-1:0]   idx_cur;
  logic [NUM_RAM-1:0]  bank_oh;

  // ARMED accepts the burst's first word, so its index is always 0
  always_comb begin
    rd_hit  = usb_rd_state == RD_CODE;
    idx_cur = (state_q == ST_ARMED) ? '0 : idx_q;
    accept  = rd_hit &&
              (state_q == ST_ARMED || state_q == ST_BURST);
    last    = accept && idx_cur == LAST_IDX;
  end

  ram_bank_dec #(
    .NUM_RAM (NUM_RAM)
  ) u_dec (
    .bank_sel_i (bank_q),
    .en_i       (1'b1),
    .onehot_o   (bank_oh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      q_q      <= '0;
      wraddr_q <= '0;
      wren_q   <= '0;
      bank_q   <= '0;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wren_q  <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      if (accept) begin
        q_q      <= data;
        wraddr_q <= idx_cur;
        wren_q   <= bank_oh;
        idx_q    <= idx_cur + ADDR_W'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (USB3_FLAGA) state_q <= ST_ARMED;
        end
        ST_ARMED, ST_BURST: begin
          if (last) begin
            state_q <= ST_CLOSE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            bank_q  <= (bank_q == LAST_BANK) ?
                       '0 : bank_q + SEL_W'(1);
          end else if (state_q == ST_BURST && !USB3_FLAGA) begin
            state_q <= ST_CLOSE;
            short_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (accept) begin
            state_q <= ST_BURST;
            busy_q  <= 1'b1;
          end else if (!USB3_FLAGA) begin
            state_q <= ST_IDLE;
          end
        end
        ST_CLOSE: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RAM_CACHE_MC_STATS_EN
  logic [15:0] bcnt_q;
  logic [15:0] scnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (done_q && bcnt_q != 16'hFFFF) bcnt_q <= bcnt_q + 16'd1;
      if (short_q && scnt_q != 16'hFFFF) scnt_q <= scnt_q + 16'd1;
    end
  end

  assign burst_cnt = bcnt_q;
  assign short_cnt = scnt_q;
`endif

  assign q            = q_q;
  assign wraddr       = wraddr_q;
  assign wren_for_ram = wren_q;
  assign bank_sel     = bank_q;
  assign burst_done   = done_q;
  assign short_burst  = short_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ram_cache_mc.sv
// tb_ram_cache_mc: directed burst scenarios plus random traffic
// checked cycle by cycle against a burst-level reference model.
module tb_ram_cache_mc;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic [3:0]  rds;
  logic        flag;
  logic [31:0] q;
  logic [7:0]  wraddr;
  logic [15:0] wren_for_ram;
  logic [3:0]  bank_sel;
  logic        burst_done;
  logic        short_burst;
  logic        busy;
`ifdef RAM_CACHE_MC_STATS_EN
  logic [15:0] burst_cnt;
  logic [15:0] short_cnt;
`endif

  ram_cache_mc dut (
    .clk          (clk),
    .rst          (rst),
    .data         (din),
    .usb_rd_state (rds),
    .USB3_FLAGA   (flag),
    .q            (q),
    .wraddr       (wraddr),
    .wren_for_ram (wren_for_ram),
    .bank_sel     (bank_sel),
`ifdef RAM_CACHE_MC_STATS_EN
    .burst_cnt    (burst_cnt),
    .short_cnt    (short_cnt),
`endif
    .burst_done   (burst_done),
    .short_burst  (short_burst),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: 0 idle, 1 armed, 2 burst, 3 close
  int          m_mode, m_cnt, m_bank, m_addr, m_bc, m_sc;
  logic [31:0] m_q;
  logic [15:0] m_wren;
  bit          m_done, m_short, m_busy;

  task automatic mstep(input bit f, input logic [3:0] s,
                       input logic [31:0] d, input bit r);
    int idx;
    bit hit;
    m_wren  = '0;
    m_done  = 0;
    m_short = 0;
    if (r) begin
      m_mode = 0; m_cnt = 0; m_bank = 0; m_addr = 0;
      m_q = '0; m_busy = 0; m_bc = 0; m_sc = 0;
      return;
    end
    hit = (s == 4'd6);
    case (m_mode)
      0: if (f) m_mode = 1;
      1, 2: begin
        idx = (m_mode == 1) ? 0 : m_cnt;
        if (hit) begin
          m_q    = d;
          m_addr = idx;
          m_wren = 16'(1 << m_bank);
          m_cnt  = idx + 1;
        end
        if (hit && idx == 255) begin
          m_mode = 3; m_done = 1; m_bank = (m_bank + 1) % 16;
        end else if (m_mode == 2 && !f) begin
          m_mode = 3; m_short = 1;
        end else if (hit) begin
          m_mode = 2;
        end else if (!f) begin
          m_mode = 0;
        end
      end
      default: m_mode = 0;
    endcase
    m_busy = (m_mode == 2);
    if (m_done && m_bc < 65535) m_bc++;
    if (m_short && m_sc < 65535) m_sc++;
  endtask

  int          n_wr, n_done, n_short;
  logic [15:0] first_wren;
  logic [7:0]  first_addr;

  task automatic clr();
    n_wr = 0; n_done = 0; n_short = 0;
  endtask

  task automatic cyc(input bit f, input logic [3:0] s,
                     input logic [31:0] d, input bit r);
    flag = f; rds = s; din = d; rst = r;
    @(posedge clk);
    mstep(f, s, d, r);
    #1;
    check("q", 64'(q), 64'(m_q));
    check("wraddr", 64'(wraddr), 64'(m_addr));
    check("wren", 64'(wren_for_ram), 64'(m_wren));
    check("bank_sel", 64'(bank_sel), 64'(m_bank));
    check("burst_done", 64'(burst_done), 64'(m_done));
    check("short_burst", 64'(short_burst), 64'(m_short));
    check("busy", 64'(busy), 64'(m_busy));
`ifdef RAM_CACHE_MC_STATS_EN
    check("burst_cnt", 64'(burst_cnt), 64'(m_bc));
    check("short_cnt", 64'(short_cnt), 64'(m_sc));
`endif
    if (burst_done) n_done++;
    if (short_burst) n_short++;
    if (|wren_for_ram) n_wr++;
  endtask

  task automatic arm();
    cyc(1, 4'd0, $urandom, 0);
  endtask

  task automatic words(input int n, input bit fixed,
                       input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      cyc(1, 4'd6, fixed ? d : $urandom, 0);
      if (i == 0) begin
        first_wren = wren_for_ram;
        first_addr = wraddr;
      end
    end
  endtask

  task automatic full();
    arm();
    words(256, 0, '0);
    cyc(1, 4'd0, '0, 0);
  endtask

  task automatic short_b(input int n);
    arm();
    words(n, 0, '0);
    cyc(0, 4'd0, '0, 0);
    cyc(0, 4'd0, '0, 0);
  endtask

  task automatic do_rst();
    cyc(0, 4'd0, '0, 1);
    clr();
  endtask

  function automatic logic [3:0] not_rd();
    int v;
    v = $urandom_range(0, 14);
    if (v >= 6) v++;
    return 4'(v);
  endfunction

  initial begin
    bit          f;
    logic [3:0]  s;
    flag = 0; rds = '0; din = '0; rst = 1;
    do_rst();
    do_rst();

    arm();
    words(256, 1, 32'hAAAAAAAA);
    cyc(1, 4'd0, '0, 0);
    check("b034_writes", 64'(n_wr), 64'd256);
    check("b034_done", 64'(n_done), 64'd1);
    check("b034_bank", 64'(bank_sel), 64'd1);

    do_rst();
    repeat (17) full();
    check("b035_done", 64'(n_done), 64'd17);
    check("b035_wren17", 64'(first_wren), 64'h0001);
    check("b035_bank", 64'(bank_sel), 64'd1);

    do_rst();
    short_b(253);
    check("b036_short", 64'(n_short), 64'd1);
    check("b036_bank", 64'(bank_sel), 64'd0);
    full();
    check("b036_addr0", 64'(first_addr), 64'd0);
    check("b036_wren", 64'(first_wren), 64'h0001);
    check("b036_done", 64'(n_done), 64'd1);

    do_rst();
    arm();
    words(101, 0, '0);
    repeat (3) cyc(1, 4'd0, $urandom, 0);
    check("b037_gapwr", 64'(n_wr), 64'd101);
    words(1, 0, '0);
    check("b037_addr", 64'(first_addr), 64'd101);
    words(154, 0, '0);
    cyc(1, 4'd0, '0, 0);
    check("b037_done", 64'(n_done), 64'd1);

    do_rst();
    arm();
    words(50, 0, '0);
    cyc(1, 4'd6, $urandom, 1);
    check("b038_wren", 64'(wren_for_ram), 64'd0);
    check("b038_pulses", 64'(n_done + n_short), 64'd0);
    full();
    check("b038_addr0", 64'(first_addr), 64'd0);
    check("b038_bank0", 64'(first_wren), 64'h0001);

    do_rst();
    arm();
    words(255, 0, '0);
    cyc(0, 4'd6, $urandom, 0);
    cyc(0, 4'd0, '0, 0);
    check("b025_done", 64'(n_done), 64'd1);
    check("b025_short", 64'(n_short), 64'd0);
    check("b025_writes", 64'(n_wr), 64'd256);
    arm();
    cyc(0, 4'd0, '0, 0);
    cyc(0, 4'd6, $urandom, 0);
    check("armdrop_wr", 64'(n_wr), 64'd256);

`ifdef RAM_CACHE_MC_STATS_EN
    do_rst();
    repeat (3) full();
    repeat (2) short_b(100);
    check("b039_bcnt", 64'(burst_cnt), 64'd3);
    check("b039_scnt", 64'(short_cnt), 64'd2);
`endif

    do_rst();
    for (int i = 0; i < 4000; i++) begin
      f = ($urandom_range(0, 299) != 0);
      s = (f && $urandom_range(0, 4) != 0) ? 4'd6 : not_rd();
      cyc(f, s, $urandom, $urandom_range(0, 1999) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_cache_mc.md
RAM_CACHE_MC -- requirements
Module: ram_cache_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of USB word and RAM write data.
REQ-002 SHALL have parameter NUM_RAM, default 16, number of destination RAM banks (2..32).
REQ-003 SHALL have parameter BURST_LEN, default 256, words per full burst (power of two).
REQ-004 SHALL have parameter RD_CODE, default 4'd6, usb_rd_state value marking a valid read word.
REQ-005 SHALL have parameter ADDR_W, default $clog2(BURST_LEN), RAM write address width.
REQ-006 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port data  in  DATA_W  USB3 slave-FIFO read data.
REQ-009 SHALL have port usb_rd_state  in  4  USB read FSM state code.
REQ-010 SHALL have port USB3_FLAGA  in  1  FX3 data-available flag.
REQ-011 SHALL have port q  out  DATA_W  registered RAM write data.
REQ-012 SHALL have port wraddr  out  ADDR_W  RAM write address.
REQ-013 SHALL have port wren_for_ram  out  NUM_RAM  one-hot per-bank write enable.
REQ-014 SHALL have port bank_sel  out  $clog2(NUM_RAM)  bank currently being filled.
REQ-015 SHALL have port burst_done  out  1  one-cycle pulse on full-burst completion.
REQ-016 SHALL have port short_burst  out  1  one-cycle pulse on truncated burst.
REQ-017 SHALL have port busy  out  1  high while in BURST state.

Function
REQ-018 SHALL implement FSM IDLE -> ARMED -> BURST -> CLOSE -> IDLE.
REQ-019 IDLE -> ARMED when USB3_FLAGA=1; ARMED -> BURST on first cycle usb_rd_state==RD_CODE; ARMED -> IDLE if FLAGA drops first.
REQ-020 Word accepted every cycle in BURST (or the ARMED->BURST cycle) with usb_rd_state==RD_CODE.
REQ-021 Accepted word: next cycle q=data, wraddr=word index, wren_for_ram=1<<bank_sel; latency exactly 1 cycle; wren all-zero otherwise.
REQ-022 Word index starts 0 per burst, increments per accepted word; gaps (usb_rd_state!=RD_CODE, FLAGA=1) hold index, no write.
REQ-023 Word BURST_LEN-1 accepted -> CLOSE; burst_done pulses in CLOSE; bank_sel advances, wraps NUM_RAM-1 -> 0.
REQ-024 FLAGA=0 in BURST with index < BURST_LEN -> CLOSE with short_burst pulse; bank_sel NOT advanced; next burst rewrites same bank from address 0.
REQ-025 FLAGA falling in same cycle as final word: word written, full burst (burst_done), not short.
REQ-026 CLOSE lasts exactly one cycle, accepts no words; RD_CODE in CLOSE ignored.
REQ-027 busy=1 in BURST only.

Reset
REQ-028 rst=1 forces IDLE, q=0, wraddr=0, wren_for_ram=0, bank_sel=0, burst_done=0, short_burst=0, busy=0 on next edge.
REQ-029 rst mid-burst abandons burst, no pulse; no write in cycle after reset asserts.

Configuration
REQ-030 Macro RAM_CACHE_MC_STATS_EN, when defined, adds outputs burst_cnt (16b) and short_cnt (16b), counting burst_done/short_burst pulses, saturating at 16'hFFFF, cleared by rst.
REQ-031 Without RAM_CACHE_MC_STATS_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Package ram_cache_pkg SHALL hold FSM state enum, RD_CODE default and default DATA_W/NUM_RAM/BURST_LEN constants.
REQ-033 One-hot bank decode SHALL be sub-module ram_bank_dec (bank_sel, en -> one-hot), sized by NUM_RAM.

Verification
REQ-034 FLAGA=1, 256 consecutive RD_CODE words 32'hAAAAAAAA -> 256 writes to bank 0, addr 0..255, burst_done once, bank_sel=1.
REQ-035 17 back-to-back full bursts, NUM_RAM=16 -> bank_sel sequence 0..15,0; 17th burst writes wren_for_ram=16'h0001.
REQ-036 FLAGA drops after 253 words -> short_burst pulse, bank_sel unchanged; next burst rewrites same bank from addr 0.
REQ-037 3-cycle usb_rd_state=0 gap after word 100 -> no writes in gap, next word at addr 101.
REQ-038 rst pulsed at word 50 -> all outputs 0 next cycle, no burst_done/short_burst, next burst bank 0 addr 0.
REQ-039 With RAM_CACHE_MC_STATS_EN: 3 full + 2 short bursts -> burst_cnt=3, short_cnt=2.
